// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and its ALU control decoder.
// JAL_SUPPORT_EN adds the JAL_WB state and makes opcode 000011 legal.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_BRANCH,
        S_JUMP,
`ifdef JAL_SUPPORT_EN
        S_JAL_WB,
`endif
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_LW,
        CLS_SW,
        CLS_ADDI,
        CLS_ORI,
        CLS_LUI,
        CLS_ANDI,
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_ILLEGAL
    } op_cls_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_LW    = 3'b101;
    localparam logic [2:0] ALU_SW    = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic op_cls_e decode_op(input logic [5:0] op);
        op_cls_e c;
        case (op)
            OP_RTYPE: c = CLS_R;
            OP_LW:    c = CLS_LW;
            OP_SW:    c = CLS_SW;
            OP_ADDI:  c = CLS_ADDI;
            OP_ORI:   c = CLS_ORI;
            OP_LUI:   c = CLS_LUI;
            OP_ANDI:  c = CLS_ANDI;
            OP_BEQ:   c = CLS_BEQ;
            OP_J:     c = CLS_J;
`ifdef JAL_SUPPORT_EN
            OP_JAL:   c = CLS_JAL;
`endif
            default:  c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] itype_alu_op(input op_cls_e c);
        logic [2:0] a;
        case (c)
            CLS_ORI:  a = ALU_OR;
            CLS_LUI:  a = ALU_LUI;
            CLS_ANDI: a = ALU_AND;
            default:  a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Moore control word for a state; the FETCH ir/pc write strobes are added by the top.
    function automatic ctrl_t ctrl_of(input state_e s, input op_cls_e c);
        ctrl_t r;
        r = '0;
        case (s)
            S_FETCH: begin
                r.mem_read  = 1'b1;
                r.alu_src_b = ALUB_FOUR;
                r.pc_source = PCSRC_ALU;
                r.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                r.alu_src_b = ALUB_SHIMM;
                r.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                r.alu_src_a = 1'b1;
                r.alu_src_b = ALUB_IMM;
                r.alu_op    = (c == CLS_SW) ? ALU_SW : ALU_LW;
            end
            S_MEM_READ: begin
                r.mem_read = 1'b1;
                r.iord     = 1'b1;
            end
            S_MEM_WB: begin
                r.reg_write  = 1'b1;
                r.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                r.mem_write = 1'b1;
                r.iord      = 1'b1;
            end
            S_EXEC_R: begin
                r.alu_src_a = 1'b1;
                r.alu_src_b = ALUB_REG;
                r.alu_op    = ALU_RTYPE;
            end
            S_WB_R: begin
                r.reg_write = 1'b1;
                r.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                r.alu_src_a = 1'b1;
                r.alu_src_b = ALUB_IMM;
                r.alu_op    = itype_alu_op(c);
            end
            S_WB_I: r.reg_write = 1'b1;
            S_BRANCH: begin
                r.alu_src_a     = 1'b1;
                r.alu_src_b     = ALUB_REG;
                r.alu_op        = ALU_SUB;
                r.pc_write_cond = 1'b1;
                r.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                r.pc_write  = 1'b1;
                r.pc_source = PCSRC_JUMP;
            end
`ifdef JAL_SUPPORT_EN
            // Link write: reg_dst forced to select $31, data is the already-incremented PC.
            S_JAL_WB: begin
                r.reg_write = 1'b1;
                r.reg_dst   = 1'b1;
            end
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle: opcode/flags/handshake in, datapath controls out.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       fault;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
               alu_op, fault
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
               alu_op, fault
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter: counts cycles spent waiting for mem_ready, flags the last allowed cycle.
// Cleared whenever the controller is not waiting, so every wait state entry starts from zero.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting_i,
    output logic expire_o
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign cnt_d    = waiting_i ? (cnt_q + CW'(1)) : '0;
    // A miss in this cycle makes the count reach MEM_TIMEOUT; a hit still counts as success.
    assign expire_o = (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with registered Moore controls, memory timeout and sticky fault.
// Define JAL_SUPPORT_EN to run JAL as JUMP then JAL_WB; otherwise opcode 000011 halts.
// state     | meaning
// FETCH     | read instruction; ir/pc write in the mem_ready cycle
// DECODE    | classify opcode, branch target into ALUOut
// MEM_*     | LW/SW address calc, read, writeback, write
// EXEC/WB   | R-type and I-type compute, then register write
// BRANCH    | BEQ compare, conditional PC write
// JUMP      | PC <- jump target; JAL_WB writes the link register
// HALT      | fault raised, parked until reset
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);
    import mips_ctrl_pkg::*;

    state_e  state_q, state_d;
    op_cls_e cls_q, cls_d, cls_dec;
    ctrl_t   ctl_q;
    logic    fault_q;
    logic    in_wait, waiting, wait_expire, fetch_ack;

    assign cls_dec = decode_op(bus.opcode);
    assign cls_d   = (state_q == S_DECODE) ? cls_dec : cls_q;
    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign waiting = in_wait && !bus.mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting_i(waiting),
        .expire_o (wait_expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)    state_d = S_DECODE;
                else if (wait_expire) state_d = S_HALT;
            end
            S_DECODE: begin
                case (cls_dec)
                    CLS_R:                                 state_d = S_EXEC_R;
                    CLS_LW, CLS_SW:                        state_d = S_MEM_ADDR;
                    CLS_ADDI, CLS_ORI, CLS_LUI, CLS_ANDI:  state_d = S_EXEC_I;
                    CLS_BEQ:                               state_d = S_BRANCH;
                    CLS_J:                                 state_d = S_JUMP;
`ifdef JAL_SUPPORT_EN
                    CLS_JAL:                               state_d = S_JUMP;
`endif
                    default:                               state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR:  state_d = (cls_q == CLS_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (bus.mem_ready)    state_d = S_MEM_WB;
                else if (wait_expire) state_d = S_HALT;
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (bus.mem_ready)    state_d = S_FETCH;
                else if (wait_expire) state_d = S_HALT;
            end
            S_EXEC_R:    state_d = S_WB_R;
            S_WB_R:      state_d = S_FETCH;
            S_EXEC_I:    state_d = S_WB_I;
            S_WB_I:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
`ifdef JAL_SUPPORT_EN
            S_JUMP:      state_d = (cls_q == CLS_JAL) ? S_JAL_WB : S_FETCH;
            S_JAL_WB:    state_d = S_FETCH;
`else
            S_JUMP:      state_d = S_FETCH;
`endif
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_NONE;
            ctl_q   <= ctrl_of(S_FETCH, CLS_NONE);
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            ctl_q   <= ctrl_of(state_d, cls_d);
            if (state_d == S_HALT) fault_q <= 1'b1;
        end
    end

    // Instruction capture must coincide with the memory handshake, so it is the one gated strobe.
    assign fetch_ack = (state_q == S_FETCH) && bus.mem_ready && reset;

    assign bus.pc_write      = ctl_q.pc_write | fetch_ack;
    assign bus.ir_write      = fetch_ack;
    assign bus.pc_write_cond = ctl_q.pc_write_cond;
    assign bus.iord          = ctl_q.iord;
    assign bus.mem_read      = ctl_q.mem_read;
    assign bus.mem_write     = ctl_q.mem_write;
    assign bus.mem_to_reg    = ctl_q.mem_to_reg;
    assign bus.reg_write     = ctl_q.reg_write;
    assign bus.reg_dst       = ctl_q.reg_dst;
    assign bus.alu_src_a     = ctl_q.alu_src_a;
    assign bus.alu_src_b     = ctl_q.alu_src_b;
    assign bus.pc_source     = ctl_q.pc_source;
    assign bus.alu_op        = ctl_q.alu_op;
    assign bus.fault         = fault_q;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, max cycles a memory state waits for mem_ready before raising the fault.
REQ-002 Port: clk  input  1  single system clock, all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: opcode  input  6  instruction[31:26], sampled only in DECODE.
REQ-005 Port: zero  input  1  ALU zero flag, used in BRANCH.
REQ-006 Port: mem_ready  input  1  memory handshake, access complete this cycle.
REQ-007 Ports: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  output  1 each  Moore datapath controls.
REQ-008 Ports: alu_src_b  output  2  (00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm) and pc_source  output  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-009 Port: alu_op  output  3  ALU control class: 111 R-type, 000 add/ADDI, 001 ORI, 010 LUI, 011 ANDI, 100 BEQ/sub, 101 LW, 110 SW.
REQ-010 Port: fault  output  1  sticky error: illegal opcode or memory timeout.

Function
REQ-011 FSM states: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, JAL_WB, HALT.
REQ-012 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; ir_write and pc_write asserted only in the cycle mem_ready=1; then DECODE, else stay.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target to ALUOut); next state by opcode.
REQ-014 Opcode map: 000000->EXEC_R; 100011 LW, 101011 SW->MEM_ADDR; 001000 ADDI, 001101 ORI, 001111 LUI, 001100 ANDI->EXEC_I; 000100 BEQ->BRANCH; 000010 J->JUMP; 000011 JAL->JUMP (JAL_EN only); any other->HALT with fault=1.
REQ-015 The opcode class shall be registered in DECODE and held until the next FETCH; alu_op in MEM_ADDR shall be 101 (LW) or 110 (SW), in EXEC_I the matching I-type code.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10; next MEM_READ (LW) or MEM_WRITE (SW).
REQ-017 MEM_READ: mem_read=1, iord=1; on mem_ready->MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
REQ-018 MEM_WRITE: mem_write=1, iord=1; on mem_ready->FETCH.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111; ->WB_R (reg_write=1, reg_dst=1, mem_to_reg=0) ->FETCH.
REQ-020 EXEC_I: alu_src_a=1, alu_src_b=10; ->WB_I (reg_write=1, reg_dst=0) ->FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=100, pc_write_cond=1, pc_source=01; ->FETCH regardless of zero.
REQ-022 JUMP: pc_write=1, pc_source=10; ->JAL_WB for JAL, else FETCH.
REQ-023 Memory wait counter: reset to 0 on entry to FETCH/MEM_READ/MEM_WRITE, increments each waiting cycle; reaching MEM_TIMEOUT without mem_ready -> HALT, fault=1.
REQ-024 mem_ready in the same cycle the counter reaches MEM_TIMEOUT counts as success.
REQ-025 HALT: all enables 0, alu_op=000; remains until reset.
REQ-026 All outputs not listed for a state shall be 0; outputs shall be glitch-free functions of registered state only.

Reset
REQ-027 reset low shall immediately force state FETCH, wait counter 0, opcode class 0, fault 0, regardless of current state including mid-memory-wait.
REQ-028 While reset low, outputs shall equal FETCH values with pc_write=0, ir_write=0; first fetch handshake accepted on the first edge after release.

Configuration
REQ-029 Macro JAL_SUPPORT_EN: defined -> opcode 000011 runs JUMP then JAL_WB (reg_write=1, register $31 select via reg_dst=1 override, PC+4 source); undefined -> 000011 is illegal (HALT, fault=1) and JAL_WB is absent.

Structure
REQ-030 Package mips_ctrl_pkg shall hold state enum, opcode constants, alu_op codes, alu_src_b/pc_source encodings; the alu_op codes shall be shared with the ALU control decoder.
REQ-031 One sub-module, mem_wait_timer (counter + timeout compare), instantiated once.

Verification
REQ-032 LW (100011), mem_ready on first cycle each access -> FETCH,DECODE,MEM_ADDR(alu_op=101),MEM_READ,MEM_WB,FETCH; 5 cycles.
REQ-033 R-type, mem_ready delayed 3 cycles in FETCH -> ir_write/pc_write pulse once at cycle 4, EXEC_R alu_op=111, WB_R reg_dst=1.
REQ-034 BEQ with zero=1 and zero=0 -> BRANCH alu_op=100, pc_write_cond=1 both cases, return to FETCH.
REQ-035 Opcode 111111 -> HALT, fault=1 held 20 cycles; reset low clears to FETCH, fault=0.
REQ-036 MEM_TIMEOUT=4, SW with mem_ready never asserted -> HALT after 4 wait cycles; mem_ready on 4th cycle -> FETCH.
REQ-037 JAL with and without JAL_SUPPORT_EN -> JUMP then JAL_WB reg_write=1, versus HALT fault=1; reset asserted mid-MEM_READ -> FETCH asynchronously.
